// File: rtl/dual_warp_scheduler.sv
// ----------------------------------------------------------------------------
// dual_warp_scheduler
// Time-multiplexes one shared decode/ALU/PC pipeline between two warps. The
// active warp's pipeline state and PC live in core_state/current_pc. The
// inactive warp's state and PC are parked in a saved slot. When the active
// warp stalls on memory, finishes, or has not been started, and the other warp
// can make progress, the two swap on a single edge.
//
// Ports
//   clk                      rising-edge clock
//   reset                    asynchronous, active-low; clears all state
//   start_1 / start_2        launch warp 1 / warp 2
//   thread_count_1 / _2      active threads per warp
//   fetcher_state_1 / _2     per-warp fetcher state (3'b010 = FETCHED)
//   lsu_state_1 / _2         per-thread LSU state, 2 bits per thread
//   decoded_ret              active instruction is RET
//   next_pc                  per-thread next PC, 8 bits per thread
//   warp_select              0 = warp 1 active, 1 = warp 2 active
//   core_state               active warp's pipeline state
//   current_pc               active warp's PC
//   done_1 / done_2          sticky warp-complete flags
// ----------------------------------------------------------------------------
module dual_warp_scheduler #(
   parameter int unsigned THREADS_PER_BLOCK = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start_1,
   input  logic                                 start_2,
   input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count_1,
   input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count_2,
   input  logic [2:0]                           fetcher_state_1,
   input  logic [2:0]                           fetcher_state_2,
   input  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state_1,
   input  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state_2,
   input  logic                                 decoded_ret,
   input  logic [8*THREADS_PER_BLOCK-1:0]       next_pc,
   output logic                                 warp_select,
   output logic [2:0]                           core_state,
   output logic [7:0]                           current_pc,
   output logic                                 done_1,
   output logic                                 done_2
);

   localparam int unsigned CNT_W   = $clog2(THREADS_PER_BLOCK) + 1;
   localparam int unsigned PC_W    = 8;
   localparam logic [2:0]  FETCHED = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE    = 3'b000,
      S_FETCH   = 3'b001,
      S_DECODE  = 3'b010,
      S_REQUEST = 3'b011,
      S_WAIT    = 3'b100,
      S_EXECUTE = 3'b101,
      S_UPDATE  = 3'b110,
      S_DONE    = 3'b111
   } state_e;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              warp_select_q, warp_select_d;
   logic              done_1_q, done_1_d;
   logic              done_2_q, done_2_d;
   state_e            saved_state_q [2];
   state_e            saved_state_d [2];
   logic [PC_W-1:0]   saved_pc_q [2];
   logic [PC_W-1:0]   saved_pc_d [2];

   // Only the last thread's next PC is consumed; the rest are folded away.
   logic              unused_next_pc;
   assign unused_next_pc = ^next_pc;

   // A thread stalls the warp only if it is in range and mid-transaction.
   function automatic logic any_busy(input logic [2*THREADS_PER_BLOCK-1:0] lsu,
                                     input logic [CNT_W-1:0]               cnt);
      logic busy;
      busy = 1'b0;
      for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
         if ((i < 32'(cnt)) &&
             ((lsu[2*i +: 2] == 2'b01) || (lsu[2*i +: 2] == 2'b10))) begin
            busy = 1'b1;
         end
      end
      return busy;
   endfunction

   logic busy_1, busy_2;
   logic start_act, start_oth, busy_act, busy_oth;
   logic [2:0] fetch_act;
   logic oth_idx;
   logic oth_runnable;
   logic act_blocked;

   assign busy_1    = any_busy(lsu_state_1, thread_count_1);
   assign busy_2    = any_busy(lsu_state_2, thread_count_2);
   assign oth_idx   = ~warp_select_q;
   assign start_act = warp_select_q ? start_2 : start_1;
   assign start_oth = warp_select_q ? start_1 : start_2;
   assign busy_act  = warp_select_q ? busy_2  : busy_1;
   assign busy_oth  = warp_select_q ? busy_1  : busy_2;
   assign fetch_act = warp_select_q ? fetcher_state_2 : fetcher_state_1;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= S_IDLE;
         pc_q             <= '0;
         warp_select_q    <= 1'b0;
         done_1_q         <= 1'b0;
         done_2_q         <= 1'b0;
         saved_state_q[0] <= S_IDLE;
         saved_state_q[1] <= S_IDLE;
         saved_pc_q[0]    <= '0;
         saved_pc_q[1]    <= '0;
      end else begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         warp_select_q    <= warp_select_d;
         done_1_q         <= done_1_d;
         done_2_q         <= done_2_d;
         saved_state_q[0] <= saved_state_d[0];
         saved_state_q[1] <= saved_state_d[1];
         saved_pc_q[0]    <= saved_pc_d[0];
         saved_pc_q[1]    <= saved_pc_d[1];
      end
   end

   // Next-state: a warp swap takes priority over the active warp's own step
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      warp_select_d = warp_select_q;
      done_1_d      = done_1_q;
      done_2_d      = done_2_q;
      saved_state_d = saved_state_q;
      saved_pc_d    = saved_pc_q;

      unique case (saved_state_q[oth_idx])
         S_IDLE:  oth_runnable = start_oth;
         S_WAIT:  oth_runnable = ~busy_oth;
         S_DONE:  oth_runnable = 1'b0;
         default: oth_runnable = 1'b1;
      endcase

      act_blocked = ((state_q == S_WAIT) && busy_act) ||
                    (state_q == S_DONE) ||
                    ((state_q == S_IDLE) && !start_act);

      if (act_blocked && oth_runnable) begin
         saved_state_d[warp_select_q] = state_q;
         saved_pc_d[warp_select_q]    = pc_q;
         warp_select_d                = ~warp_select_q;
         // A runnable idle warp has its start high, so it launches on entry.
         if (saved_state_q[oth_idx] == S_IDLE) begin
            state_d = S_FETCH;
            pc_d    = '0;
         end else begin
            state_d = saved_state_q[oth_idx];
            pc_d    = saved_pc_q[oth_idx];
         end
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start_act) begin
                  state_d = S_FETCH;
                  pc_d    = '0;
               end
            end
            S_FETCH:   if (fetch_act == FETCHED) state_d = S_DECODE;
            S_DECODE:  state_d = S_REQUEST;
            S_REQUEST: state_d = S_WAIT;
            S_WAIT:    if (!busy_act) state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_UPDATE;
            S_UPDATE: begin
               if (decoded_ret) begin
                  state_d = S_DONE;
                  if (warp_select_q) done_2_d = 1'b1;
                  else               done_1_d = 1'b1;
               end else begin
                  state_d = S_FETCH;
                  pc_d    = next_pc[8*THREADS_PER_BLOCK-1 -: 8];
               end
            end
            S_DONE:    state_d = S_DONE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // Outputs straight from the registers
   always_comb begin
      warp_select = warp_select_q;
      core_state  = state_q;
      current_pc  = pc_q;
      done_1      = done_1_q;
      done_2      = done_2_q;
   end

endmodule

// File: tb/tb_dual_warp_scheduler.sv
// ----------------------------------------------------------------------------
// tb_dual_warp_scheduler
// Directed scoreboard bench: each step pushes the expected post-edge outputs,
// advances one clock, then pops and compares against the DUT.
// ----------------------------------------------------------------------------
module tb_dual_warp_scheduler;

   localparam int unsigned T    = 4;
   localparam int unsigned CW   = $clog2(T) + 1;

   logic              clk;
   logic              rst_n;
   logic              start_1, start_2;
   logic [CW-1:0]     thread_count_1, thread_count_2;
   logic [2:0]        fetcher_state_1, fetcher_state_2;
   logic [2*T-1:0]    lsu_state_1, lsu_state_2;
   logic              decoded_ret;
   logic [8*T-1:0]    next_pc;
   logic              warp_select;
   logic [2:0]        core_state;
   logic [7:0]        current_pc;
   logic              done_1, done_2;

   typedef struct {
      string      tag;
      logic       ws;
      logic [2:0] st;
      logic [7:0] pc;
      logic       d1;
      logic       d2;
   } exp_t;

   exp_t sb_q[$];
   int   checks;
   int   failures;

   dual_warp_scheduler #(.THREADS_PER_BLOCK(T)) dut (
      .clk             (clk),
      .reset           (rst_n),
      .start_1         (start_1),
      .start_2         (start_2),
      .thread_count_1  (thread_count_1),
      .thread_count_2  (thread_count_2),
      .fetcher_state_1 (fetcher_state_1),
      .fetcher_state_2 (fetcher_state_2),
      .lsu_state_1     (lsu_state_1),
      .lsu_state_2     (lsu_state_2),
      .decoded_ret     (decoded_ret),
      .next_pc         (next_pc),
      .warp_select     (warp_select),
      .core_state      (core_state),
      .current_pc      (current_pc),
      .done_1          (done_1),
      .done_2          (done_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic ws, input logic [2:0] st,
                                input logic [7:0] pc, input logic d1, input logic d2);
      check_eq({tag, ".ws"}, 32'(warp_select), 32'(ws));
      check_eq({tag, ".st"}, 32'(core_state),  32'(st));
      check_eq({tag, ".pc"}, 32'(current_pc),  32'(pc));
      check_eq({tag, ".d1"}, 32'(done_1),      32'(d1));
      check_eq({tag, ".d2"}, 32'(done_2),      32'(d2));
   endtask

   // Push the expectation, clock once, pop and compare after the edge
   task automatic step(input string tag, input logic ws, input logic [2:0] st,
                       input logic [7:0] pc, input logic d1, input logic d2);
      exp_t e;
      e.tag = tag; e.ws = ws; e.st = st; e.pc = pc; e.d1 = d1; e.d2 = d2;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb_q.pop_front();
         check_outputs(e.tag, e.ws, e.st, e.pc, e.d1, e.d2);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; failures = 0;
      start_1 = 1'b0; start_2 = 1'b0;
      thread_count_1 = '0; thread_count_2 = '0;
      fetcher_state_1 = 3'b000; fetcher_state_2 = 3'b000;
      lsu_state_1 = '0; lsu_state_2 = '0;
      decoded_ret = 1'b0; next_pc = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check_outputs("reset", 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
      #9 rst_n = 1'b1;
      step("idle_hold", 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);

      // Warp 1 alone through a full instruction
      start_1 = 1'b1; thread_count_1 = CW'(4); thread_count_2 = CW'(4);
      next_pc = {T{8'h05}};
      step("w1_fetch0", 1'b0, 3'b001, 8'h00, 1'b0, 1'b0);
      step("w1_fetch1", 1'b0, 3'b001, 8'h00, 1'b0, 1'b0);
      fetcher_state_1 = 3'b010;
      step("w1_decode", 1'b0, 3'b010, 8'h00, 1'b0, 1'b0);
      fetcher_state_1 = 3'b000;
      step("w1_req",    1'b0, 3'b011, 8'h00, 1'b0, 1'b0);
      step("w1_wait",   1'b0, 3'b100, 8'h00, 1'b0, 1'b0);
      step("w1_exec",   1'b0, 3'b101, 8'h00, 1'b0, 1'b0);
      step("w1_upd",    1'b0, 3'b110, 8'h00, 1'b0, 1'b0);
      step("w1_newpc",  1'b0, 3'b001, 8'h05, 1'b0, 1'b0);

      // Warp 1 stalls in WAIT; idle warp 2 with start high is swapped in
      start_1 = 1'b0; start_2 = 1'b1; fetcher_state_1 = 3'b010;
      step("w1_dec2",   1'b0, 3'b010, 8'h05, 1'b0, 1'b0);
      fetcher_state_1 = 3'b000;
      step("w1_req2",   1'b0, 3'b011, 8'h05, 1'b0, 1'b0);
      step("w1_wait2",  1'b0, 3'b100, 8'h05, 1'b0, 1'b0);
      lsu_state_1 = 8'h02;
      step("sw_to_w2",  1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
      start_2 = 1'b0; fetcher_state_2 = 3'b010; next_pc = {T{8'h03}};
      step("w2_decode", 1'b1, 3'b010, 8'h00, 1'b0, 1'b0);
      fetcher_state_2 = 3'b000;
      step("w2_req",    1'b1, 3'b011, 8'h00, 1'b0, 1'b0);
      step("w2_wait",   1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
      lsu_state_2 = 8'h04;
      step("both_busy", 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
      lsu_state_1 = 8'hFF;
      step("sw_back",   1'b0, 3'b100, 8'h05, 1'b0, 1'b0);
      step("w1_exec2",  1'b0, 3'b101, 8'h05, 1'b0, 1'b0);
      step("w1_upd2",   1'b0, 3'b110, 8'h05, 1'b0, 1'b0);
      decoded_ret = 1'b1; lsu_state_2 = 8'h00;
      step("w1_done",   1'b0, 3'b111, 8'h05, 1'b1, 1'b0);
      decoded_ret = 1'b0;
      step("sw_w2_res", 1'b1, 3'b100, 8'h00, 1'b1, 1'b0);
      step("w2_exec",   1'b1, 3'b101, 8'h00, 1'b1, 1'b0);
      step("w2_upd",    1'b1, 3'b110, 8'h00, 1'b1, 1'b0);
      step("w2_newpc",  1'b1, 3'b001, 8'h03, 1'b1, 1'b0);
      fetcher_state_2 = 3'b010;
      step("w2_dec2",   1'b1, 3'b010, 8'h03, 1'b1, 1'b0);
      fetcher_state_2 = 3'b000;
      step("w2_req2",   1'b1, 3'b011, 8'h03, 1'b1, 1'b0);
      step("w2_wait2",  1'b1, 3'b100, 8'h03, 1'b1, 1'b0);
      step("w2_exec2",  1'b1, 3'b101, 8'h03, 1'b1, 1'b0);
      step("w2_upd2",   1'b1, 3'b110, 8'h03, 1'b1, 1'b0);
      decoded_ret = 1'b1;
      step("w2_done",   1'b1, 3'b111, 8'h03, 1'b1, 1'b1);
      decoded_ret = 1'b0;
      step("both_done", 1'b1, 3'b111, 8'h03, 1'b1, 1'b1);

      // Simultaneous starts: warp 1 first; zero thread count masks busy LSUs
      rst_n = 1'b0;
      start_1 = 1'b1; start_2 = 1'b1;
      thread_count_1 = '0; lsu_state_1 = 8'hAA; fetcher_state_1 = 3'b010;
      lsu_state_2 = '0; next_pc = '0;
      #3 rst_n = 1'b1;
      step("dual_fetch",  1'b0, 3'b001, 8'h00, 1'b0, 1'b0);
      step("dual_decode", 1'b0, 3'b010, 8'h00, 1'b0, 1'b0);
      step("dual_req",    1'b0, 3'b011, 8'h00, 1'b0, 1'b0);
      step("cnt0_wait",   1'b0, 3'b100, 8'h00, 1'b0, 1'b0);
      step("cnt0_exit",   1'b0, 3'b101, 8'h00, 1'b0, 1'b0);

      // Unstarted warp 1 yields to warp 2; thread 3 is beyond thread_count_2
      rst_n = 1'b0;
      start_1 = 1'b0; start_2 = 1'b1; fetcher_state_2 = 3'b010;
      thread_count_2 = CW'(2); lsu_state_2 = 8'h82;
      #3 rst_n = 1'b1;
      step("idle_sw",   1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
      step("w2b_dec",   1'b1, 3'b010, 8'h00, 1'b0, 1'b0);
      step("w2b_req",   1'b1, 3'b011, 8'h00, 1'b0, 1'b0);
      step("w2b_wait",  1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
      step("w2b_hold",  1'b1, 3'b100, 8'h00, 1'b0, 1'b0);

      // Asynchronous reset in the middle of WAIT
      #3 rst_n = 1'b0;
      #1;
      check_outputs("async_rst", 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_outputs("rst_held", 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
      start_2 = 1'b0;
      rst_n = 1'b1;
      step("post_rst",  1'b0, 3'b000, 8'h00, 1'b0, 1'b0);

      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dual_warp_scheduler.md
Name: dual_warp_scheduler

Overview:
- Per-core scheduler that time-multiplexes one shared decode/ALU/PC pipeline between two warps.
- Keeps a saved state and PC for each warp.
- Drives the active warp's pipeline state (core_state, current_pc) plus warp_select to the downstream warp context mux.
- Switches warps when the active warp stalls on memory or finishes, hiding LSU latency.

Parameters:
- THREADS_PER_BLOCK, 4, threads per warp; sizes lsu_state arrays, next_pc array and thread_count width.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start_1 / start_2  in  1 each  launch warp 1 / warp 2.
- thread_count_1 / thread_count_2  in  $clog2(THREADS_PER_BLOCK)+1 each  active threads per warp.
- fetcher_state_1 / fetcher_state_2  in  3 each  per-warp fetcher state; 3'b010 = FETCHED.
- lsu_state_1 / lsu_state_2  in  2 x THREADS_PER_BLOCK each  per-thread LSU state: 00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE.
- decoded_ret  in  1  active instruction is RET, from the shared decoder.
- next_pc  in  8 x THREADS_PER_BLOCK  per-thread next PC from the shared PC units.
- warp_select  out  1  0 = warp 1 active, 1 = warp 2 active.
- core_state  out  3  active warp's pipeline state.
- current_pc  out  8  active warp's PC.
- done_1 / done_2  out  1 each  warp completed (sticky).

Behaviour:
- Reset (reset=0, async):
  - warp_select=0, core_state=3'b000, current_pc=0, done_1=0, done_2=0.
  - Both saved states = IDLE, both saved PCs = 0.
  - Reset mid-operation aborts immediately; no switch completes.
- State encoding: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
- Active-warp FSM, one transition per rising edge:
  - IDLE: start_k=1 -> FETCH, pc=0.
  - FETCH: fetcher_state_k==3'b010 -> DECODE; otherwise hold.
  - DECODE -> REQUEST -> WAIT, unconditionally, 1 cycle each.
  - WAIT: a thread is busy if its index < thread_count_k and its lsu_state_k is 01 or 10. No busy threads -> EXECUTE.
  - EXECUTE -> UPDATE.
  - UPDATE, decoded_ret=1 -> DONE, done_k<=1, pc unchanged.
  - UPDATE, decoded_ret=0 -> pc<=next_pc[THREADS_PER_BLOCK-1], -> FETCH.
  - DONE: hold until reset.
- Runnable (inactive warp):
  - Saved state IDLE with its start high.
  - Saved state WAIT with zero busy threads.
  - Saved state FETCH, DECODE, REQUEST, EXECUTE or UPDATE.
  - Saved state DONE is never runnable.
- Switch condition, evaluated at the edge:
  - Active warp is in WAIT with at least one busy thread, or is in DONE, and the other warp is runnable.
  - On that edge: active state/pc stored in its saved slot, warp_select toggles, core_state/current_pc load the other warp's saved state/pc.
  - The normal FSM transition is suppressed on that edge.
  - A switched-in IDLE warp with start high loads FETCH, pc=0, directly.
  - Switch latency is 1 cycle; new values are visible after the edge.
- While inactive in WAIT, a warp's LSU progress is tracked through its own lsu_state_k, so it can become runnable without being selected.
- Active warp IDLE with start low and other warp runnable: switch (same rules).
- Both starts rise on the same cycle from reset: warp 1 runs first (warp_select stays 0).
- Both warps in WAIT and busy: hold, no switch; re-evaluate every cycle.
- Both warps DONE: hold, core_state=111, done_1=done_2=1.
- thread_count_k=0: WAIT has zero busy threads, so it exits to EXECUTE after 1 cycle.
- PC arithmetic is 8-bit, taken directly from next_pc; no increment inside the block, and wrap is the producer's responsibility.
- done_k stays sticky once set; only reset clears it.

Test Plan:
- Reset mid-WAIT (reset=0 at arbitrary edge) -> all outputs zero asynchronously, before the next clk; after release, core_state=000, warp_select=0.
- start_1=1 only, fetcher_state_1=010 after 2 cycles, lsu idle, decoded_ret=0, next_pc=8'h05 -> sequence 001,001,010,011,100,101,110,001 with current_pc=05; warp_select stays 0.
- Warp 1 in WAIT with lsu_state_1[0]=10, warp 2 saved in FETCH at pc=8'h03 -> next edge: warp_select=1, core_state=001, current_pc=03; warp 1 saved as WAIT.
- Warp 2 in WAIT and busy, warp 1's LSUs drop to 11 -> switch back: warp_select=0, core_state=100, then EXECUTE next cycle.
- Warp 1 reaches UPDATE with decoded_ret=1 while warp 2 is runnable -> done_1=1, core_state=111 for 1 cycle, then switch to warp 2.
- Both starts rise together, thread_count_1=0 -> warp 1 runs first; its WAIT lasts exactly 1 cycle.
